laser_cover_check: RTL and testbench
====================================

# laser_cover_check

Downstream scoring stage for the two-circle laser placement block. It snoops the same 40-point X/Y stream the placer reads and latches the placer's final circle centres after `DONE`. It then recounts coverage (radius 4, inclusive) and reports per-circle and union counts as a one-cycle result. Point storage is double-buffered, so the next dataset is captured while the current one is scored.

## Interface
- `NPTS`, 40: points per dataset.
- `R2`, 16: squared radius; a point is inside if dx²+dy² <= R2.
- `CLK` in 1: single clock, rising edge.
- `RST` in 1: synchronous, active-high reset.
- `X`, `Y` in 4 each: point coordinates, same wires the placer samples.
- `C1X`, `C1Y`, `C2X`, `C2Y` in 4 each: placer centre outputs.
- `DONE` in 1: placer completion strobe.
- `RES_VALID` out 1: one-cycle result strobe.
- `C1_CNT`, `C2_CNT`, `U_CNT` out 6 each: points in circle 1, in circle 2, and in either circle (union).
- `PROTO_ERR` out 1: sticky protocol-violation flag.
- `COVER_MAP` out 40: per-point union-hit bitmap; present only with the macro.

## Operation
- **Capture FSM:** states `CAP_FILL` and `CAP_HOLD`. It writes into bank `wr_bank`.
  - `CAP_FILL`: store X/Y at `pt[wr_bank][cap_idx]` on every edge; `cap_idx` runs 0..39. At 39 go to `CAP_HOLD` and set `bank_full[wr_bank]`.
  - `CAP_HOLD`: on the edge after a `DONE` is accepted, toggle `wr_bank`, clear `cap_idx` and return to `CAP_FILL`.
- **Eval FSM:** states `E_IDLE`, `E_ARM`, `E_RUN`, `E_REPORT`. It reads bank `rd_bank`.
  - `E_IDLE`: if `DONE`=1, the capture FSM is in `CAP_HOLD` and `bank_full[rd_bank]` is set, then accept and go to `E_ARM`.
  - `E_ARM`: latch C1X..C2Y into internal centre registers (the placer's centres are final only one cycle after `DONE`). Clear the accumulators and `ev_idx`. Go to `E_RUN`.
  - `E_RUN`: evaluate `pt[rd_bank][ev_idx]`, one point per cycle. The hit results are registered (one pipeline stage) and then accumulated. After `ev_idx`=39 plus one drain cycle, go to `E_REPORT`.
  - `E_REPORT`: drive counts and `RES_VALID`=1. Clear `bank_full[rd_bank]`, toggle `rd_bank`, go to `E_IDLE`.
- **Arithmetic:**
  - dx = |px − cx| (4-bit unsigned); same for dy.
  - Squares are 8-bit; the sum is 9-bit, so there is no overflow.
  - The compare is <= R2 (equality counts as inside).
  - A point inside both circles increments `C1_CNT` and `C2_CNT`, but `U_CNT` only once. Counts saturate at 40 by construction.
- **Violations:** all three set `PROTO_ERR` (sticky until `RST`).
  - `DONE` in `CAP_FILL`: ignored.
  - `DONE` while eval is not in `E_IDLE`: ignored.
  - Capture reaches `CAP_HOLD` while the other bank is still full: capture stalls in `CAP_HOLD` with no overwrite.
- **Reset (including mid-operation):** both FSMs return to their initial states, both banks become empty, `wr_bank`=`rd_bank`=0, all outputs go to 0. Any partial dataset is discarded.

## Timing
- First rising edge with `RST`=0 samples point 0; points 1..39 follow on consecutive edges.
- `DONE` accepted at edge t:
  - Centres are latched at edge t+1.
  - The next dataset's point 0 is captured at edge t+2 into the other bank.
  - `ev_idx` 0..39 are evaluated at edges t+2..t+41.
  - The last hit is accumulated at t+42.
  - `RES_VALID` is high in the cycle following edge t+43, for exactly one cycle.
- Counts and `COVER_MAP` hold their value until the next `E_REPORT`.
- Reset value of every output: 0.

## Configuration
- `LASER_CHK_BITMAP_EN` defined: `COVER_MAP[i]` = union hit of point i. It is updated at `E_REPORT` and held between reports.
- Not defined: the `COVER_MAP` port and its 40-bit register are absent. Count behaviour is identical.

## Structure
- Package `laser_pkg`:
  - Constants: `NPTS`, `R2`, `COORD_W`=4, `CNT_W`=6.
  - Enums: `cap_state_t`, `ev_state_t`.
  - Point struct: {x, y}.
- Sub-module `laser_in_circle`: combinational. Inputs: point and centre. Output: hit. It is instantiated twice (circle 1 and circle 2).

## Test plan
- Reset, 40 points all at (5,5), `DONE` with C1=(5,5), C2=(0,0) → `C1_CNT`=40, `C2_CNT`=0, `U_CNT`=40, `RES_VALID` one cycle after edge t+43.
- Boundary: point (9,5), C1=(5,5) (dist²=16) and point (9,6) (dist²=17) → first counted, second not.
- Overlap: 10 points inside both circles, 30 outside → `C1_CNT`=`C2_CNT`=`U_CNT`=10.
- Back-to-back datasets: second stream starts at t+2 while scoring the first → both results correct, second result independent of the first.
- `DONE` at cycle 20 of capture → ignored, `PROTO_ERR`=1, no `RES_VALID`.
- `RST` asserted during `E_RUN` → all outputs 0 next cycle; a fresh dataset scores correctly.

Source files
------------

// File: rtl/laser_pkg.sv
// Shared types and constants for the laser coverage scoring stage.
// Coordinates are 4-bit unsigned; counts are 6-bit, enough to reach NPTS.
package laser_pkg;

  localparam int NPTS    = 40;
  localparam int R2      = 16;
  localparam int COORD_W = 4;
  localparam int CNT_W   = 6;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } pt_t;

  typedef enum logic {
    CAP_FILL,
    CAP_HOLD
  } cap_state_t;

  typedef enum logic [1:0] {
    E_IDLE,
    E_ARM,
    E_RUN,
    E_REPORT
  } ev_state_t;

  function automatic coord_t abs_diff(input coord_t a, input coord_t b);
    return (a >= b) ? coord_t'(a - b) : coord_t'(b - a);
  endfunction

endpackage

// File: rtl/laser_in_circle.sv
// Combinational point-in-circle test: dx^2 + dy^2 <= R2, boundary counts as inside.
// Squares fit in 8 bits and the sum in 9 bits, so nothing can overflow.
module laser_in_circle
  import laser_pkg::*;
(
  input  pt_t    pt_i,
  input  coord_t cx_i,
  input  coord_t cy_i,
  output logic   hit_o
);

  coord_t     dx;
  coord_t     dy;
  logic [7:0] sq_x;
  logic [7:0] sq_y;
  logic [8:0] dist2;

  assign dx    = abs_diff(pt_i.x, cx_i);
  assign dy    = abs_diff(pt_i.y, cy_i);
  assign sq_x  = {4'b0000, dx} * {4'b0000, dx};
  assign sq_y  = {4'b0000, dy} * {4'b0000, dy};
  assign dist2 = {1'b0, sq_x} + {1'b0, sq_y};
  assign hit_o = (dist2 <= 9'(R2));

endmodule

// File: rtl/laser_cover_check.sv
// Rescores the placer's two circles over a double-buffered 40-point dataset; result strobe 43 edges after DONE.
// Optional per-point union bitmap on COVER_MAP when LASER_CHK_BITMAP_EN is defined.
module laser_cover_check
  import laser_pkg::*;
(
  input  logic               CLK,
  input  logic               RST,
  input  logic [COORD_W-1:0] X,
  input  logic [COORD_W-1:0] Y,
  input  logic [COORD_W-1:0] C1X,
  input  logic [COORD_W-1:0] C1Y,
  input  logic [COORD_W-1:0] C2X,
  input  logic [COORD_W-1:0] C2Y,
  input  logic               DONE,
  output logic               RES_VALID,
  output logic [CNT_W-1:0]   C1_CNT,
  output logic [CNT_W-1:0]   C2_CNT,
  output logic [CNT_W-1:0]   U_CNT,
  output logic               PROTO_ERR
`ifdef LASER_CHK_BITMAP_EN
  ,
  output logic [NPTS-1:0]    COVER_MAP
`endif
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NPTS - 1);
  localparam logic [CNT_W-1:0] NPTS_C   = CNT_W'(NPTS);

  cap_state_t       cap_q, cap_d;
  ev_state_t        ev_q, ev_d;

  logic [CNT_W-1:0] cap_idx_q;
  logic [CNT_W-1:0] ev_idx_q;
  logic             wr_bank_q;
  logic             rd_bank_q;
  logic [1:0]       bank_full_q;

  pt_t              pts_q [2][NPTS];

  coord_t           c1x_q, c1y_q, c2x_q, c2y_q;
  logic             hit1_q, hit2_q, hv_q;
  logic [CNT_W-1:0] c1_acc_q, c2_acc_q, u_acc_q;
  logic [CNT_W-1:0] c1_cnt_q, c2_cnt_q, u_cnt_q;
  logic             res_vld_q;
  logic             err_q;

  logic             done_ok;
  logic             fill_last;
  logic             err_now;
  logic [CNT_W-1:0] rd_idx;
  pt_t              rd_pt;
  logic             hit1, hit2;

  assign done_ok   = DONE && (ev_q == E_IDLE) && (cap_q == CAP_HOLD) && bank_full_q[rd_bank_q];
  assign fill_last = (cap_q == CAP_FILL) && (cap_idx_q == LAST_IDX);

  // A completed fill finding the other bank still loaded with nobody scoring it
  // means an unscored dataset would be stranded; capture simply parks in HOLD.
  assign err_now = (DONE && ((cap_q == CAP_FILL) || (ev_q != E_IDLE)))
                || (fill_last && bank_full_q[~wr_bank_q] && (ev_q == E_IDLE));

  assign rd_idx = (ev_idx_q < NPTS_C) ? ev_idx_q : '0;
  assign rd_pt  = pts_q[rd_bank_q][rd_idx];

  laser_in_circle u_circ1 (
    .pt_i  (rd_pt),
    .cx_i  (c1x_q),
    .cy_i  (c1y_q),
    .hit_o (hit1)
  );

  laser_in_circle u_circ2 (
    .pt_i  (rd_pt),
    .cx_i  (c2x_q),
    .cy_i  (c2y_q),
    .hit_o (hit2)
  );

  always_comb begin
    cap_d = cap_q;
    case (cap_q)
      CAP_FILL: if (fill_last) cap_d = CAP_HOLD;
      CAP_HOLD: if (ev_q == E_ARM) cap_d = CAP_FILL;
      default:  cap_d = CAP_FILL;
    endcase
  end

  always_comb begin
    ev_d = ev_q;
    case (ev_q)
      E_IDLE:   if (done_ok) ev_d = E_ARM;
      E_ARM:    ev_d = E_RUN;
      E_RUN:    if (ev_idx_q == NPTS_C) ev_d = E_REPORT;
      E_REPORT: ev_d = E_IDLE;
      default:  ev_d = E_IDLE;
    endcase
  end

  // Point storage carries no reset; bank_full gates every read of it.
  always_ff @(posedge CLK) begin
    if (!RST && (cap_q == CAP_FILL)) begin
      pts_q[wr_bank_q][cap_idx_q] <= '{x: X, y: Y};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cap_q       <= CAP_FILL;
      ev_q        <= E_IDLE;
      cap_idx_q   <= '0;
      ev_idx_q    <= '0;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      bank_full_q <= '0;
      c1x_q       <= '0;
      c1y_q       <= '0;
      c2x_q       <= '0;
      c2y_q       <= '0;
      hit1_q      <= 1'b0;
      hit2_q      <= 1'b0;
      hv_q        <= 1'b0;
      c1_acc_q    <= '0;
      c2_acc_q    <= '0;
      u_acc_q     <= '0;
      c1_cnt_q    <= '0;
      c2_cnt_q    <= '0;
      u_cnt_q     <= '0;
      res_vld_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      cap_q     <= cap_d;
      ev_q      <= ev_d;
      res_vld_q <= 1'b0;
      err_q     <= err_q | err_now;

      if (cap_q == CAP_FILL) begin
        if (fill_last) begin
          bank_full_q[wr_bank_q] <= 1'b1;
        end else begin
          cap_idx_q <= cap_idx_q + 1'b1;
        end
      end else if (ev_q == E_ARM) begin
        wr_bank_q <= ~wr_bank_q;
        cap_idx_q <= '0;
      end

      if (hv_q) begin
        c1_acc_q <= c1_acc_q + CNT_W'(hit1_q);
        c2_acc_q <= c2_acc_q + CNT_W'(hit2_q);
        u_acc_q  <= u_acc_q + CNT_W'(hit1_q | hit2_q);
      end

      case (ev_q)
        E_ARM: begin
          // Placer centres settle one cycle after its DONE strobe.
          c1x_q    <= C1X;
          c1y_q    <= C1Y;
          c2x_q    <= C2X;
          c2y_q    <= C2Y;
          c1_acc_q <= '0;
          c2_acc_q <= '0;
          u_acc_q  <= '0;
          ev_idx_q <= '0;
          hv_q     <= 1'b0;
        end
        E_RUN: begin
          hit1_q <= hit1;
          hit2_q <= hit2;
          hv_q   <= (ev_idx_q != NPTS_C);
          if (ev_idx_q != NPTS_C) ev_idx_q <= ev_idx_q + 1'b1;
        end
        E_REPORT: begin
          c1_cnt_q               <= c1_acc_q;
          c2_cnt_q               <= c2_acc_q;
          u_cnt_q                <= u_acc_q;
          res_vld_q              <= 1'b1;
          bank_full_q[rd_bank_q] <= 1'b0;
          rd_bank_q              <= ~rd_bank_q;
        end
        default: ;
      endcase
    end
  end

`ifdef LASER_CHK_BITMAP_EN
  logic [CNT_W-1:0] hit_idx_q;
  logic [NPTS-1:0]  map_acc_q;
  logic [NPTS-1:0]  cover_map_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      hit_idx_q   <= '0;
      map_acc_q   <= '0;
      cover_map_q <= '0;
    end else begin
      if (ev_q == E_RUN) hit_idx_q <= ev_idx_q;
      if (ev_q == E_ARM) begin
        map_acc_q <= '0;
      end else if (hv_q && (hit1_q || hit2_q)) begin
        for (int i = 0; i < NPTS; i++) begin
          if (hit_idx_q == CNT_W'(i)) map_acc_q[i] <= 1'b1;
        end
      end
      if (ev_q == E_REPORT) cover_map_q <= map_acc_q;
    end
  end

  assign COVER_MAP = cover_map_q;
`endif

  assign RES_VALID = res_vld_q;
  assign C1_CNT    = c1_cnt_q;
  assign C2_CNT    = c2_cnt_q;
  assign U_CNT     = u_cnt_q;
  assign PROTO_ERR = err_q;

endmodule

// File: tb/tb_laser_cover_check.sv
// Directed bench for laser_cover_check: hand-computed coverage counts, result latency and protocol errors.
module tb_laser_cover_check;
  import laser_pkg::*;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic [3:0]   X = '0, Y = '0;
  logic [3:0]   C1X = '0, C1Y = '0, C2X = '0, C2Y = '0;
  logic         DONE = 1'b0;
  logic         RES_VALID;
  logic [5:0]   C1_CNT, C2_CNT, U_CNT;
  logic         PROTO_ERR;
`ifdef LASER_CHK_BITMAP_EN
  logic [39:0]  COVER_MAP;
`endif

  laser_cover_check dut (
    .CLK       (CLK),
    .RST       (RST),
    .X         (X),
    .Y         (Y),
    .C1X       (C1X),
    .C1Y       (C1Y),
    .C2X       (C2X),
    .C2Y       (C2Y),
    .DONE      (DONE),
    .RES_VALID (RES_VALID),
    .C1_CNT    (C1_CNT),
    .C2_CNT    (C2_CNT),
    .U_CNT     (U_CNT),
    .PROTO_ERR (PROTO_ERR)
`ifdef LASER_CHK_BITMAP_EN
    ,
    .COVER_MAP (COVER_MAP)
`endif
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_err = 0;
  logic [3:0] px [40];
  logic [3:0] py [40];

  task automatic chk(input string tag, input logic [39:0] got, input logic [39:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST  = 1'b1;
    DONE = 1'b0;
    repeat (3) tick();
    RST = 1'b0;
  endtask

  task automatic send_pts();
    for (int i = 0; i < 40; i++) begin
      X = px[i];
      Y = py[i];
      tick();
    end
  endtask

  task automatic pulse_done(input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d);
    C1X  = a;
    C1Y  = b;
    C2X  = c;
    C2Y  = d;
    DONE = 1'b1;
    tick();
    DONE = 1'b0;
  endtask

  // Called right after the DONE edge; expects the strobe after exactly 43 more edges.
  task automatic wait_res(input string tag, input int e1, input int e2, input int eu);
    int k;
    k = 0;
    for (int i = 1; i <= 60; i++) begin
      tick();
      if (RES_VALID === 1'b1) begin
        k = i;
        break;
      end
    end
    chk({tag, ".latency"}, 40'(k), 40'd43);
    chk({tag, ".c1"}, 40'(C1_CNT), 40'(e1));
    chk({tag, ".c2"}, 40'(C2_CNT), 40'(e2));
    chk({tag, ".u"},  40'(U_CNT),  40'(eu));
    tick();
    chk({tag, ".strobe_width"}, 40'(RES_VALID), 40'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nv;
    logic [39:0] exp_map;

    RST = 1'b1;
    repeat (3) tick();
    chk("rst.valid", 40'(RES_VALID), 40'd0);
    chk("rst.c1",    40'(C1_CNT),    40'd0);
    chk("rst.c2",    40'(C2_CNT),    40'd0);
    chk("rst.u",     40'(U_CNT),     40'd0);
    chk("rst.err",   40'(PROTO_ERR), 40'd0);

    // All points at (5,5), C1 on them, C2 far away.
    do_reset();
    for (int i = 0; i < 40; i++) begin px[i] = 4'd5; py[i] = 4'd5; end
    send_pts();
    pulse_done(4'd5, 4'd5, 4'd0, 4'd0);
    wait_res("basic", 40, 0, 40);

    // Boundary: dist2 of 16 inside, 17/18 outside, both signs of dx.
    do_reset();
    for (int i = 0; i < 40; i++) begin px[i] = 4'd15; py[i] = 4'd15; end
    px[0] = 4'd9; py[0] = 4'd5;
    px[1] = 4'd9; py[1] = 4'd6;
    px[2] = 4'd1; py[2] = 4'd5;
    px[3] = 4'd5; py[3] = 4'd9;
    px[4] = 4'd8; py[4] = 4'd8;
    px[5] = 4'd7; py[5] = 4'd8;
    send_pts();
    pulse_done(4'd5, 4'd5, 4'd0, 4'd15);
    wait_res("boundary", 4, 0, 4);

    // Overlap: every fourth point inside both circles.
    do_reset();
    exp_map = '0;
    for (int i = 0; i < 40; i++) begin
      if (i % 4 == 0) begin
        px[i] = 4'd5; py[i] = 4'd5; exp_map[i] = 1'b1;
      end else begin
        px[i] = 4'd15; py[i] = 4'd0;
      end
    end
    send_pts();
    pulse_done(4'd4, 4'd4, 4'd6, 4'd6);
    wait_res("overlap", 10, 10, 10);
`ifdef LASER_CHK_BITMAP_EN
    chk("overlap.map", COVER_MAP, exp_map);
`endif

    // DONE in the middle of capture is a protocol error and is dropped.
    do_reset();
    for (int i = 0; i < 40; i++) begin px[i] = 4'd3; py[i] = 4'd3; end
    C1X = 4'd3; C1Y = 4'd3; C2X = 4'd3; C2Y = 4'd3;
    for (int i = 0; i < 40; i++) begin
      X = px[i];
      Y = py[i];
      DONE = (i == 20);
      tick();
      if (i == 20) chk("early_done.err", 40'(PROTO_ERR), 40'd1);
    end
    DONE = 1'b0;
    nv = 0;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (RES_VALID === 1'b1) nv++;
    end
    chk("early_done.no_result", 40'(nv), 40'd0);
    chk("early_done.sticky", 40'(PROTO_ERR), 40'd1);

    // Back-to-back: second stream captured while the first is scored.
    do_reset();
    for (int i = 0; i < 40; i++) begin
      px[i] = (i < 25) ? 4'd2 : 4'd12;
      py[i] = (i < 25) ? 4'd2 : 4'd12;
    end
    send_pts();
    pulse_done(4'd2, 4'd2, 4'd12, 4'd12);
    for (int i = 0; i < 40; i++) begin
      px[i] = (i < 7) ? 4'd3 : 4'd13;
      py[i] = (i < 7) ? 4'd13 : 4'd3;
    end
    fork
      begin
        tick();
        send_pts();
      end
      wait_res("b2b_first", 25, 15, 40);
    join
    pulse_done(4'd3, 4'd13, 4'd0, 4'd0);
    wait_res("b2b_second", 7, 0, 7);

    // Score the filler dataset, then reset partway through the run.
    repeat (45) tick();
    pulse_done(4'd13, 4'd3, 4'd0, 4'd0);
    repeat (10) tick();
    chk("mid.held_c1", 40'(C1_CNT), 40'd7);
    RST = 1'b1;
    tick();
    chk("mid_rst.valid", 40'(RES_VALID), 40'd0);
    chk("mid_rst.c1",    40'(C1_CNT),    40'd0);
    chk("mid_rst.c2",    40'(C2_CNT),    40'd0);
    chk("mid_rst.u",     40'(U_CNT),     40'd0);
    chk("mid_rst.err",   40'(PROTO_ERR), 40'd0);
    RST = 1'b0;
    for (int i = 0; i < 40; i++) begin
      px[i] = (i % 2 == 0) ? 4'd0 : 4'd15;
      py[i] = (i % 2 == 0) ? 4'd0 : 4'd15;
    end
    send_pts();
    pulse_done(4'd2, 4'd2, 4'd15, 4'd11);
    wait_res("fresh", 20, 20, 40);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
